// File: rtl/aes_req_ctrl.sv
// rtl/aes_req_ctrl.sv - two-requester round-robin front end for the byte-serial AES-128 core
//
// Arbitrates between two 128-bit encrypt requests and sequences the core through
// reset, a 16-cycle byte load of state and key, and a fixed processing wait. It then
// returns the captured ciphertext on a valid/ready response channel.
//
// Optional feature macro: AES_CTRL_STATS_EN (adds per-requester response counters).
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   reqN_valid/ready/data/key (N=0,1)  request channels; byte 0 = [127:120]
//   rsp_valid/ready/text/id            ciphertext response channel
//   core_reset                         high holds the core idle
//   core_state, core_key               byte-serial load bus to the core
//   core_text                          ciphertext from the core
//   busy                               high in every state except IDLE
//   stat_cnt0, stat_cnt1               saturating response counts (AES_CTRL_STATS_EN only)
module aes_req_ctrl #(
  parameter int CORE_LATENCY = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_text,
  output logic         rsp_id,
  output logic         core_reset,
  output logic [7:0]   core_state,
  output logic [7:0]   core_key,
  input  logic [127:0] core_text,
  output logic         busy
`ifdef AES_CTRL_STATS_EN
  ,
  output logic [15:0]  stat_cnt0,
  output logic [15:0]  stat_cnt1
`endif
);

  typedef enum logic [2:0] {IDLE, PRIME, LOAD, WAIT, RESP} state_t;

  state_t       state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic [7:0]   wcnt, wcnt_n;
  logic         last;
  logic [127:0] data_q, key_q;
  logic         hshake, eval, pick0, pick1, grant;
  logic [127:0] data_sh, key_sh;
  logic         nxt_core_reset, nxt_busy, nxt_rsp_valid;
  logic [7:0]   nxt_core_state, nxt_core_key;

  // Next-state and arbitration.
  // The grant decision is taken in an IDLE cycle that has no pending pulse, or in the
  // response handshake cycle, so the registered ready pulse lands in the following
  // IDLE cycle and the FSM leaves for PRIME right after it.
  always_comb begin
    state_n = state;
    hshake  = (state == RESP) && rsp_ready;
    eval    = ((state == IDLE) && !(req0_ready || req1_ready)) || hshake;
    pick0   = eval && req0_valid && (!req1_valid || last);
    pick1   = eval && req1_valid && !pick0;
    grant   = pick0 || pick1;
    cnt_n   = (state == LOAD) ? cnt + 4'd1 : 4'd0;
    wcnt_n  = 8'd0;
    case (state)
      IDLE:  if (req0_ready || req1_ready) state_n = PRIME;
      PRIME: state_n = LOAD;
      LOAD: begin
        if (cnt == 4'd15) begin
          state_n = WAIT;
          wcnt_n  = 8'(CORE_LATENCY);
        end
      end
      WAIT: begin
        wcnt_n = wcnt - 8'd1;
        if (wcnt == 8'd1) state_n = RESP;
      end
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the next cycle; every output is registered from these.
  always_comb begin
    data_sh        = data_q << {cnt_n, 3'b000};
    key_sh         = key_q << {cnt_n, 3'b000};
    nxt_core_reset = !((state_n == PRIME) || (state_n == LOAD) || (state_n == WAIT));
    nxt_busy       = (state_n != IDLE);
    nxt_rsp_valid  = (state_n == RESP);
    nxt_core_state = 8'd0;
    nxt_core_key   = 8'd0;
    if (state_n == LOAD) begin
      nxt_core_state = data_sh[127:120];
      nxt_core_key   = key_sh[127:120];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wcnt       <= 8'd0;
      last       <= 1'b1;
      data_q     <= 128'd0;
      key_q      <= 128'd0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_text   <= 128'd0;
      rsp_id     <= 1'b0;
      core_reset <= 1'b1;
      core_state <= 8'd0;
      core_key   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wcnt       <= wcnt_n;
      req0_ready <= pick0;
      req1_ready <= pick1;
      rsp_valid  <= nxt_rsp_valid;
      core_reset <= nxt_core_reset;
      core_state <= nxt_core_state;
      core_key   <= nxt_core_key;
      busy       <= nxt_busy;
      if (grant) begin
        last   <= pick1;
        rsp_id <= pick1;
        data_q <= pick0 ? req0_data : req1_data;
        key_q  <= pick0 ? req0_key : req1_key;
      end
      if ((state == WAIT) && (wcnt == 8'd1)) rsp_text <= core_text;
    end
  end

`ifdef AES_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt0 <= 16'd0;
      stat_cnt1 <= 16'd0;
    end else if (hshake) begin
      if (!rsp_id && (stat_cnt0 != 16'hFFFF)) stat_cnt0 <= stat_cnt0 + 16'd1;
      if (rsp_id && (stat_cnt1 != 16'hFFFF)) stat_cnt1 <= stat_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_ctrl.sv
// tb/tb_aes_req_ctrl.sv - scoreboard bench for aes_req_ctrl with a behavioural core
module tb_aes_req_ctrl;
  localparam int LAT = 16;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic rsp_valid, rsp_ready, rsp_id, core_reset, busy;
  logic [127:0] rsp_text, core_text;
  logic [7:0] core_state, core_key;
`ifdef AES_CTRL_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         id;
    logic [127:0] text;
  } exp_t;
  exp_t sb[$];

  aes_req_ctrl #(.CORE_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_id(rsp_id),
    .core_reset(core_reset), .core_state(core_state), .core_key(core_key),
    .core_text(core_text), .busy(busy)
`ifdef AES_CTRL_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the core: known-answer for the FIPS vector, otherwise a byte-order
  // sensitive mix. Output is garbage until 28 cycles after leaving reset.
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic [7:0]   mc;
  logic [127:0] m_pt, m_key;
  always @(posedge clk) begin
    if (core_reset) begin
      mc    <= 8'd0;
      m_pt  <= 128'd0;
      m_key <= 128'd0;
    end else begin
      if (mc != 8'hff) mc <= mc + 8'd1;
      if (mc >= 8'd1 && mc <= 8'd16) begin
        m_pt  <= {m_pt[119:0], core_state};
        m_key <= {m_key[119:0], core_key};
      end
    end
  end
  assign core_text = (!core_reset && mc >= 8'd28) ? model_ct(m_pt, m_key) : 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_ready(input int who, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic get_rsp(output logic id, output logic [127:0] text, output int t, output bit ok);
    ok = 1'b0;
    t = 0;
    id = 1'b0;
    text = 128'd0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        t = cyc;
        id = rsp_id;
        text = rsp_text;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    checks++; if (rsp_text !== 128'd0) begin failures++; $display("FAIL rst_rsp_text: got %h want 0", rsp_text); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL rst_rsp_id: got %b want 0", rsp_id); end
    checks++; if ({core_state, core_key} !== 16'd0) begin failures++; $display("FAIL rst_core_bytes: got %h want 0", {core_state, core_key}); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fips();
    int tg, tr;
    bit ok;
    logic id;
    logic [127:0] txt;
    exp_t e;
    rsp_ready = 1'b1;
    tick();
    req0_data = FIPS_PT;
    req0_key = FIPS_KEY;
    req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, text: FIPS_CT});
    wait_ready(0, tg, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fips_grant: got no req0_ready want pulse"); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL fips_r1_ready: got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (core_reset !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fips_prime: got core_reset=%b busy=%b want 0 1", core_reset, busy); end
    @(negedge clk);
    checks++; if ({core_state, core_key} !== 16'h0000) begin failures++; $display("FAIL fips_byte0: got %h want 0000", {core_state, core_key}); end
    repeat (15) @(negedge clk);
    checks++; if ({core_state, core_key} !== 16'hff0f) begin failures++; $display("FAIL fips_byte15: got %h want ff0f", {core_state, core_key}); end
    get_rsp(id, txt, tr, ok);
    e = sb.pop_front();
    checks++; if (!ok || (tr - tg) !== 34) begin failures++; $display("FAIL fips_latency: got %0d want 34", tr - tg); end
    checks++; if (txt !== e.text) begin failures++; $display("FAIL fips_text: got %h want %h", txt, e.text); end
    checks++; if (id !== e.id) begin failures++; $display("FAIL fips_id: got %b want %b", id, e.id); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fips_done: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_tie();
    int tg, tprev, tr;
    bit ok;
    logic id, gid;
    logic [127:0] txt;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    req0_data = {$urandom, $urandom, $urandom, $urandom};
    req0_key  = {$urandom, $urandom, $urandom, $urandom};
    req1_data = {$urandom, $urandom, $urandom, $urandom};
    req1_key  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++)
      sb.push_back('{id: k[0], text: (k[0] ? model_ct(req1_data, req1_key) : model_ct(req0_data, req0_key))});
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tprev = 0;
    for (int op = 0; op < 4; op++) begin
      ok = 1'b0;
      tg = 0;
      gid = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          tg = cyc;
          gid = req1_ready;
          checks++; if (req0_ready && req1_ready) begin failures++; $display("FAIL tie_one_grant: got both ready want one"); end
        end
      end
      e = sb.pop_front();
      checks++; if (!ok || gid !== e.id) begin failures++; $display("FAIL tie_order op%0d: got %b want %b", op, gid, e.id); end
      if (op > 0) begin
        checks++; if (tg - tprev !== 19 + LAT) begin failures++; $display("FAIL tie_period: got %0d want %0d", tg - tprev, 19 + LAT); end
      end
      tprev = tg;
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL tie_pulse: got %b want 00", {req0_ready, req1_ready}); end
      if (op == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      get_rsp(id, txt, tr, ok);
      checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL tie_rsp op%0d: got %b/%h want %b/%h", op, id, txt, e.id, e.text); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int tg, tr, h;
    bit ok;
    logic id;
    logic [127:0] txt;
    exp_t e;
    bit e_valid, e_text, e_id, e_busy, e_grant;
    do_reset();
    rsp_ready = 1'b0;
    req0_data = {$urandom, $urandom, $urandom, $urandom};
    req0_key  = {$urandom, $urandom, $urandom, $urandom};
    req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, text: model_ct(req0_data, req0_key)});
    wait_ready(0, tg, ok);
    tick();
    req0_valid = 1'b0;
    get_rsp(id, txt, tr, ok);
    e = sb.pop_front();
    checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL bp_rsp: got %b/%h want %b/%h", id, txt, e.id, e.text); end
    req1_data = {$urandom, $urandom, $urandom, $urandom};
    req1_key  = {$urandom, $urandom, $urandom, $urandom};
    req1_valid = 1'b1;
    sb.push_back('{id: 1'b1, text: model_ct(req1_data, req1_key)});
    {e_valid, e_text, e_id, e_busy, e_grant} = 5'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1) e_valid = 1'b1;
      if (rsp_text !== e.text) e_text = 1'b1;
      if (rsp_id !== e.id) e_id = 1'b1;
      if (busy !== 1'b1) e_busy = 1'b1;
      if (req0_ready || req1_ready) e_grant = 1'b1;
    end
    checks++; if (e_valid) begin failures++; $display("FAIL bp_valid_stable: got drop want held 1"); end
    checks++; if (e_text) begin failures++; $display("FAIL bp_text_stable: got change want %h", e.text); end
    checks++; if (e_id) begin failures++; $display("FAIL bp_id_stable: got change want %b", e.id); end
    checks++; if (e_busy) begin failures++; $display("FAIL bp_busy: got 0 want 1"); end
    checks++; if (e_grant) begin failures++; $display("FAIL bp_no_grant: got ready pulse want none"); end
    rsp_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || cyc !== h + 1) begin failures++; $display("FAIL bp_next_grant: got %b want 1", req1_ready); end
    req1_valid = 1'b0;
    get_rsp(id, txt, tr, ok);
    e = sb.pop_front();
    checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL bp_rsp1: got %b/%h want %b/%h", id, txt, e.id, e.text); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    int tg, tr;
    bit ok;
    logic id;
    logic [127:0] txt, d;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    req0_data = d;
    req0_key  = {$urandom, $urandom, $urandom, $urandom};
    req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, text: model_ct(req0_data, req0_key)});
    wait_ready(0, tg, ok);
    tick();
    req0_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (core_state !== d[71:64]) begin failures++; $display("FAIL mid_byte7: got %h want %h", core_state, d[71:64]); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (core_reset !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async: got core_reset=%b busy=%b valid=%b want 1 0 0", core_reset, busy, rsp_valid); end
    checks++; if (core_state !== 8'd0) begin failures++; $display("FAIL mid_core_state: got %h want 00", core_state); end
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
    req1_data = {$urandom, $urandom, $urandom, $urandom};
    req1_key  = {$urandom, $urandom, $urandom, $urandom};
    req1_valid = 1'b1;
    sb.push_back('{id: 1'b1, text: model_ct(req1_data, req1_key)});
    wait_ready(1, tg, ok);
    tick();
    req1_valid = 1'b0;
    get_rsp(id, txt, tr, ok);
    e = sb.pop_front();
    checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL mid_rsp: got %b/%h want %b/%h", id, txt, e.id, e.text); end
    @(negedge clk);
  endtask

  task automatic test_busy_block();
    int tg, tr, h;
    bit ok, blocked_err;
    logic id;
    logic [127:0] txt;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    req0_data = {$urandom, $urandom, $urandom, $urandom};
    req0_key  = {$urandom, $urandom, $urandom, $urandom};
    req0_valid = 1'b1;
    sb.push_back('{id: 1'b0, text: model_ct(req0_data, req0_key)});
    wait_ready(0, tg, ok);
    tick();
    req0_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if ({core_state, core_key} !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL busy_wait_bytes: got %h busy=%b want 0000 1", {core_state, core_key}, busy); end
    req1_data = {$urandom, $urandom, $urandom, $urandom};
    req1_key  = {$urandom, $urandom, $urandom, $urandom};
    req1_valid = 1'b1;
    sb.push_back('{id: 1'b1, text: model_ct(req1_data, req1_key)});
    ok = 1'b0;
    blocked_err = 1'b0;
    h = 0;
    id = 1'b0;
    txt = 128'd0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req1_ready) blocked_err = 1'b1;
      if (rsp_valid) begin
        ok = 1'b1;
        h = cyc;
        id = rsp_id;
        txt = rsp_text;
      end
    end
    checks++; if (blocked_err) begin failures++; $display("FAIL busy_blocked: got req1_ready=1 want 0"); end
    e = sb.pop_front();
    checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL busy_rsp0: got %b/%h want %b/%h", id, txt, e.id, e.text); end
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || cyc !== h + 1) begin failures++; $display("FAIL busy_next_grant: got %b want 1", req1_ready); end
    req1_valid = 1'b0;
    get_rsp(id, txt, tr, ok);
    e = sb.pop_front();
    checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL busy_rsp1: got %b/%h want %b/%h", id, txt, e.id, e.text); end
    @(negedge clk);
  endtask

`ifdef AES_CTRL_STATS_EN
  task automatic test_stats();
    int tg, tr;
    bit ok;
    logic id;
    logic [127:0] txt;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req1_data = {$urandom, $urandom, $urandom, $urandom};
      req1_key  = {$urandom, $urandom, $urandom, $urandom};
      req1_valid = 1'b1;
      sb.push_back('{id: 1'b1, text: model_ct(req1_data, req1_key)});
      wait_ready(1, tg, ok);
      tick();
      req1_valid = 1'b0;
      get_rsp(id, txt, tr, ok);
      e = sb.pop_front();
      checks++; if (!ok || txt !== e.text || id !== e.id) begin failures++; $display("FAIL stats_rsp%0d: got %b/%h want %b/%h", k, id, txt, e.id, e.text); end
    end
    @(negedge clk);
    checks++; if (stat_cnt1 !== 16'd3 || stat_cnt0 !== 16'd0) begin failures++; $display("FAIL stats_count: got %0d/%0d want 0/3", stat_cnt0, stat_cnt1); end
    do_reset();
    @(negedge clk);
    checks++; if (stat_cnt1 !== 16'd0 || stat_cnt0 !== 16'd0) begin failures++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_cnt0, stat_cnt1); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 128'd0;
    req0_key = 128'd0;
    req1_data = 128'd0;
    req1_key = 128'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_fips();
    test_tie();
    test_back_pressure();
    test_reset_mid_load();
    test_busy_block();
`ifdef AES_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
